header_slot_tracker: RTL and testbench
======================================

# header_slot_tracker

Per-frame-slot header bookkeeping for the EtherBlade frame buffer, generalised to `2**LINE_AW` slots with a configurable header window. On the write side it captures the frame's last-byte offset and, when the frame is 802.1Q-tagged, its full 12-bit VLAN ID, then commits both into the slot on `wr_tlast`. On the read side it presents slot length, VLAN and header-end flag to the header read logic, and tracks slot validity and occupancy.

## Interface
Parameters:
- `LINE_AW`, 2: slot address width; slot count is `2**LINE_AW`.
- `WR_OFF_W`, 11: write byte-offset width within a slot.
- `RD_OFF_W`, 9: read header-offset width.
- `HDR_LEN`, 32: header bytes per slot; must be at most `2**RD_OFF_W`.
- `VLAN_POS`, 14: offset of the first TCI byte; the TPID sits at `VLAN_POS-2` and `VLAN_POS-1`.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `wr_we`, in, 1: a byte is written this cycle.
- `wr_line`, in, `LINE_AW`: slot being written.
- `wr_off`, in, `WR_OFF_W`: offset of the byte within the slot.
- `wr_tdata`, in, 8: byte value.
- `wr_tlast`, in, 1: last byte of the frame; qualified by `wr_we`.
- `rd_line`, in, `LINE_AW`: slot being read.
- `rd_off`, in, `RD_OFF_W`: header byte offset being read.
- `rd_release`, in, 1: frees slot `rd_line`.
- `tlast_flag`, out, 1: `rd_off == HDR_LEN-1` and the slot is valid.
- `body_length`, out, 16: zero-extended stored last-byte offset, or 0 when the slot is invalid.
- `vlan_id`, out, 12: stored VLAN ID, or 0 when the slot is invalid or untagged.
- `vlan_tagged`, out, 1: the stored frame carried TPID 0x8100.
- `slot_valid`, out, 1: valid bit of `rd_line`.
- `occupancy`, out, `LINE_AW+1`: number of valid slots.
- `full`, out, 1: `occupancy == 2**LINE_AW`.
- `empty`, out, 1: `occupancy == 0`.
- `err_overwrite`, out, 1: one-cycle pulse when a commit lands on a slot that is already valid.

## Operation
- Write FSM states: `W_IDLE`, `W_HDR`, `W_BODY`.
  - `W_IDLE` to `W_HDR`: `wr_we` with `wr_off==0`. Shadow registers are cleared on this write and capture this byte.
  - `W_HDR` to `W_BODY`: write at `wr_off==VLAN_POS+1`.
  - Any state to `W_IDLE`: commit (`wr_we && wr_tlast`).
  - A write at `wr_off==0` in `W_HDR` or `W_BODY` restarts the frame: shadows clear, the state returns to `W_HDR`, and no commit occurs.
- Shadow capture happens in `W_HDR` (and on the `wr_off==0` byte) only:
  - TPID hi byte at `VLAN_POS-2`, lo byte at `VLAN_POS-1`.
  - TCI[11:8] at `VLAN_POS`, from `wr_tdata[3:0]`.
  - TCI[7:0] at `VLAN_POS+1`.
- Tagged means TPID == 0x8100 **and** both TCI bytes were captured. A frame that ends before `VLAN_POS+1` commits as untagged with VLAN 0.
- Commit writes slot `wr_line` with `{len=wr_off, vlan, tagged}` and sets the slot's valid bit.
  - The byte written on the commit cycle itself counts toward capture. This means a capture byte that arrives with `wr_tlast` is included.
- Release clears the valid bit of `rd_line`. Releasing an invalid slot is ignored and leaves `occupancy` unchanged.
- Commit and release on the **same** slot in the same cycle: commit wins, the slot ends valid, and `occupancy` does not change.
- Commit and release on **different** slots in the same cycle: both take effect, and `occupancy` is unchanged.
- `occupancy` update:
  - +1 on a commit to an invalid slot.
  - −1 on a valid release.
  - A commit to an already-valid slot leaves `occupancy` unchanged and pulses `err_overwrite`.
- Outputs are combinational from the slot registers, indexed by `rd_line` and `rd_off`.

## Timing
- Reset values: all valid bits 0, FSM in `W_IDLE`, shadows 0, `occupancy` 0, `empty` 1, `full` 0, `err_overwrite` 0. Consequently `tlast_flag`, `body_length`, `vlan_id`, `vlan_tagged` and `slot_valid` all read 0.
- A commit on edge N is visible on the read outputs after edge N. A release on edge N deasserts `slot_valid` after edge N.
- Read-address to output is a zero-cycle combinational path.
- `err_overwrite` is registered: it is high for exactly the cycle after the offending edge.
- Asserting `rst_n` mid-frame discards the shadows. The frame is not committed and no pulse is emitted.

## Structure
- Shared package `ebv1_hdr_pkg` holds:
  - the TPID constant 16'h8100;
  - the write-FSM state encoding;
  - default parameter values (`HDR_LEN`, `VLAN_POS`).
- Sub-module `header_slot_regfile`: an array of `2**LINE_AW` entries of `{len, vlan, tagged, valid}`, with one commit port, one release port and an asynchronous read port.
- The top level contains the write FSM, the shadow registers, the occupancy counter and the output muxing.

## Test plan
- Tagged frame into slot 1: bytes 0..63 with offsets 12/13 = 0x81/0x00, 14/15 = 0x0A/0xBC, `wr_tlast` at 63, then `rd_line=1`. Expect `body_length` 63, `vlan_id` 0xABC, `vlan_tagged` 1, `occupancy` 1; `tlast_flag` high only at `rd_off` 31.
- Untagged frame (TPID 0x0800) into slot 0, 60 bytes. Expect `vlan_tagged` 0, `vlan_id` 0, `body_length` 59.
- Runt frame with `wr_tlast` at offset 14 and TPID 0x8100. Expect `vlan_tagged` 0 and `body_length` 14.
- Fill slots 0..3, then commit to slot 2 again. Expect `full` 1, `err_overwrite` high for one cycle, `occupancy` still 4.
- Same-cycle commit and release to slot 3, then a release of invalid slot 1. Expect slot 3 to remain valid and `occupancy` unchanged in both cases.
- Assert `rst_n` low mid-header after committing 2 slots. Expect all outputs 0, `empty` 1, and no commit of the partial frame.

Source files
------------

// File: rtl/header_slot_tracker_pkg.sv
// Shared definitions for the EtherBlade header slot tracker.
//   - TPID value that marks an 802.1Q-tagged frame
//   - write-side FSM state encoding
//   - default header window and VLAN tag position
package ebv1_hdr_pkg;

  localparam logic [15:0] TPID_VLAN = 16'h8100;

  localparam int HDR_LEN_DEFAULT  = 32;
  localparam int VLAN_POS_DEFAULT = 14;

  // Write FSM encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_HDR  = 2'd1;
  localparam logic [1:0] W_BODY = 2'd2;

endpackage

// File: rtl/header_slot_regfile.sv
// Per-slot header storage: {len, vlan, tagged, valid} for 2**LINE_AW slots.
// Ports:
//   clk, rst_n              - clock, async active-low reset (valid bits only)
//   commit, commit_line     - write an entry and set its valid bit
//   commit_len/vlan/tagged  - entry contents for the commit
//   rel_en, rel_line        - clear the valid bit of a slot
//   rd_line                 - asynchronous read address
//   rd_len/vlan/tagged/valid- entry at rd_line
//   commit_hit              - valid bit of commit_line before this edge
module header_slot_regfile #(
  parameter int LINE_AW = 2,
  parameter int LEN_W   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               commit,
  input  logic [LINE_AW-1:0] commit_line,
  input  logic [LEN_W-1:0]   commit_len,
  input  logic [11:0]        commit_vlan,
  input  logic               commit_tagged,
  input  logic               rel_en,
  input  logic [LINE_AW-1:0] rel_line,
  input  logic [LINE_AW-1:0] rd_line,
  output logic [LEN_W-1:0]   rd_len,
  output logic [11:0]        rd_vlan,
  output logic               rd_tagged,
  output logic               rd_valid,
  output logic               commit_hit
);

  localparam int SLOTS = 2 ** LINE_AW;

  logic [LEN_W-1:0] len_q    [SLOTS];
  logic [11:0]      vlan_q   [SLOTS];
  logic             tagged_q [SLOTS];
  logic [SLOTS-1:0] valid_q;

  // NOTE: the payload array has no reset; every read of it is qualified by
  // the valid bit, so only valid_q needs a defined reset value.
  always_ff @(posedge clk) begin
    if (commit) begin
      len_q[commit_line]    <= commit_len;
      vlan_q[commit_line]   <= commit_vlan;
      tagged_q[commit_line] <= commit_tagged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      // Release first, commit second: on the same slot the later
      // non-blocking update wins, so a commit keeps the slot valid.
      if (rel_en) valid_q[rel_line] <= 1'b0;
      if (commit) valid_q[commit_line] <= 1'b1;
    end
  end

  assign rd_len     = len_q[rd_line];
  assign rd_vlan    = vlan_q[rd_line];
  assign rd_tagged  = tagged_q[rd_line];
  assign rd_valid   = valid_q[rd_line];
  assign commit_hit = valid_q[commit_line];

endmodule

// File: rtl/header_slot_tracker.sv
// Header bookkeeping for the frame buffer slots.
// Write side: tracks the frame header, captures TPID/TCI into shadows and
// commits {last offset, VLAN ID, tagged} into slot wr_line on wr_tlast.
// Read side: presents length/VLAN/header-end for rd_line/rd_off, tracks
// slot validity and occupancy.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   wr_we, wr_line, wr_off,
//   wr_tdata, wr_tlast         - byte write stream
//   rd_line, rd_off            - read address (combinational outputs)
//   rd_release                 - free slot rd_line
//   tlast_flag, body_length,
//   vlan_id, vlan_tagged,
//   slot_valid                 - per-slot read outputs
//   occupancy, full, empty     - slot usage
//   err_overwrite              - pulse: commit hit an already-valid slot
module header_slot_tracker
  import ebv1_hdr_pkg::*;
#(
  parameter int LINE_AW  = 2,
  parameter int WR_OFF_W = 11,
  parameter int RD_OFF_W = 9,
  parameter int HDR_LEN  = HDR_LEN_DEFAULT,
  parameter int VLAN_POS = VLAN_POS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_we,
  input  logic [LINE_AW-1:0]  wr_line,
  input  logic [WR_OFF_W-1:0] wr_off,
  input  logic [7:0]          wr_tdata,
  input  logic                wr_tlast,
  input  logic [LINE_AW-1:0]  rd_line,
  input  logic [RD_OFF_W-1:0] rd_off,
  input  logic                rd_release,
  output logic                tlast_flag,
  output logic [15:0]         body_length,
  output logic [11:0]         vlan_id,
  output logic                vlan_tagged,
  output logic                slot_valid,
  output logic [LINE_AW:0]    occupancy,
  output logic                full,
  output logic                empty,
  output logic                err_overwrite
);

  localparam logic [WR_OFF_W-1:0] OFF_TPID_HI = WR_OFF_W'(VLAN_POS - 2);
  localparam logic [WR_OFF_W-1:0] OFF_TPID_LO = WR_OFF_W'(VLAN_POS - 1);
  localparam logic [WR_OFF_W-1:0] OFF_TCI_HI  = WR_OFF_W'(VLAN_POS);
  localparam logic [WR_OFF_W-1:0] OFF_TCI_LO  = WR_OFF_W'(VLAN_POS + 1);
  localparam logic [RD_OFF_W-1:0] RD_HDR_LAST = RD_OFF_W'(HDR_LEN - 1);
  localparam logic [LINE_AW:0]    OCC_ONE     = (LINE_AW + 1)'(1);
  localparam logic [LINE_AW:0]    OCC_FULL    = (LINE_AW + 1)'(2 ** LINE_AW);

  logic [1:0]  state_q, state_n;
  logic [15:0] tpid_q, tpid_n;
  logic [11:0] tci_q, tci_n;
  logic        tci_hi_q, tci_hi_n;   // TCI[11:8] byte seen
  logic        tci_lo_q, tci_lo_n;   // TCI[7:0] byte seen

  logic restart, capture, commit, tagged_n;
  logic commit_hit, rd_valid_i, rd_tagged_i;
  logic [WR_OFF_W-1:0] rd_len_i;
  logic [11:0] rd_vlan_i;
  logic occ_inc, occ_dec;

  assign restart = wr_we && (wr_off == '0);
  assign commit  = wr_we && wr_tlast;
  // Header bytes are only captured while the header is still open; the
  // offset-0 byte opens a fresh header from any state.
  assign capture = wr_we && (restart || state_q == W_HDR);

  // Shadow values including this cycle's byte, so a capture byte that
  // arrives together with wr_tlast is part of the commit.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    tpid_n   = tpid_q;
    tci_n    = tci_q;
    tci_hi_n = tci_hi_q;
    tci_lo_n = tci_lo_q;
    if (restart) begin
      tpid_n   = '0;
      tci_n    = '0;
      tci_hi_n = 1'b0;
      tci_lo_n = 1'b0;
    end
    if (capture) begin
      if (wr_off == OFF_TPID_HI) tpid_n[15:8] = wr_tdata;
      if (wr_off == OFF_TPID_LO) tpid_n[7:0]  = wr_tdata;
      if (wr_off == OFF_TCI_HI) begin
        tci_n[11:8] = wr_tdata[3:0];
        tci_hi_n    = 1'b1;
      end
      if (wr_off == OFF_TCI_LO) begin
        tci_n[7:0] = wr_tdata;
        tci_lo_n   = 1'b1;
      end
    end
  end

  assign tagged_n = (tpid_n == TPID_VLAN) && tci_hi_n && tci_lo_n;

  always_comb begin
    state_n = state_q;
    if (commit)                                                state_n = W_IDLE;
    else if (restart)                                          state_n = W_HDR;
    else if (wr_we && state_q == W_HDR && wr_off == OFF_TCI_LO) state_n = W_BODY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= W_IDLE;
      tpid_q   <= '0;
      tci_q    <= '0;
      tci_hi_q <= 1'b0;
      tci_lo_q <= 1'b0;
    end else begin
      state_q <= state_n;
      // Shadows are dropped once committed so stray IDLE writes never
      // inherit the previous frame's tag.
      if (commit) begin
        tpid_q   <= '0;
        tci_q    <= '0;
        tci_hi_q <= 1'b0;
        tci_lo_q <= 1'b0;
      end else begin
        tpid_q   <= tpid_n;
        tci_q    <= tci_n;
        tci_hi_q <= tci_hi_n;
        tci_lo_q <= tci_lo_n;
      end
    end
  end

  header_slot_regfile #(
    .LINE_AW (LINE_AW),
    .LEN_W   (WR_OFF_W)
  ) u_regfile (
    .clk           (clk),
    .rst_n         (rst_n),
    .commit        (commit),
    .commit_line   (wr_line),
    .commit_len    (wr_off),
    .commit_vlan   (tagged_n ? tci_n : 12'h000),
    .commit_tagged (tagged_n),
    .rel_en        (rd_release),
    .rel_line      (rd_line),
    .rd_line       (rd_line),
    .rd_len        (rd_len_i),
    .rd_vlan       (rd_vlan_i),
    .rd_tagged     (rd_tagged_i),
    .rd_valid      (rd_valid_i),
    .commit_hit    (commit_hit)
  );

  // A release that collides with a commit on the same slot loses, and a
  // release of an invalid slot changes nothing.
  assign occ_inc = commit && !commit_hit;
  assign occ_dec = rd_release && rd_valid_i && !(commit && wr_line == rd_line);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy     <= '0;
      err_overwrite <= 1'b0;
    end else begin
      err_overwrite <= commit && commit_hit;
      case ({occ_inc, occ_dec})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign slot_valid  = rd_valid_i;
  assign tlast_flag  = rd_valid_i && (rd_off == RD_HDR_LAST);
  assign body_length = rd_valid_i ? 16'(rd_len_i) : 16'h0000;
  assign vlan_tagged = rd_valid_i && rd_tagged_i;
  assign vlan_id     = (rd_valid_i && rd_tagged_i) ? rd_vlan_i : 12'h000;
  assign full        = (occupancy == OCC_FULL);
  assign empty       = (occupancy == '0);

endmodule

// File: tb/tb_header_slot_tracker.sv
// Directed bench for header_slot_tracker: table-driven read-back of three
// committed frames, then hand-written sequences for overwrite, collisions,
// restart and mid-frame reset.
module tb_header_slot_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_we;
  logic [1:0]  wr_line;
  logic [10:0] wr_off;
  logic [7:0]  wr_tdata;
  logic        wr_tlast;
  logic [1:0]  rd_line;
  logic [8:0]  rd_off;
  logic        rd_release;
  logic        tlast_flag;
  logic [15:0] body_length;
  logic [11:0] vlan_id;
  logic        vlan_tagged;
  logic        slot_valid;
  logic [2:0]  occupancy;
  logic        full;
  logic        empty;
  logic        err_overwrite;

  int n_tests = 0;
  int n_fail  = 0;

  header_slot_tracker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_we         (wr_we),
    .wr_line       (wr_line),
    .wr_off        (wr_off),
    .wr_tdata      (wr_tdata),
    .wr_tlast      (wr_tlast),
    .rd_line       (rd_line),
    .rd_off        (rd_off),
    .rd_release    (rd_release),
    .tlast_flag    (tlast_flag),
    .body_length   (body_length),
    .vlan_id       (vlan_id),
    .vlan_tagged   (vlan_tagged),
    .slot_valid    (slot_valid),
    .occupancy     (occupancy),
    .full          (full),
    .empty         (empty),
    .err_overwrite (err_overwrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  line;
    logic [8:0]  off;
    logic        tl;
    logic [15:0] len;
    logic [11:0] vlan;
    logic        tag;
    logic        valid;
  } rd_vec_t;

  rd_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One byte per clock; inputs change 1 ns after the edge, checks follow
  // the last edge by the same 1 ns.
  task automatic write_frame(input logic [1:0] line, input int last,
                             input logic [7:0] b12, input logic [7:0] b13,
                             input logic [7:0] b14, input logic [7:0] b15,
                             input logic with_last, input logic rel);
    for (int i = 0; i <= last; i++) begin
      wr_we    = 1'b1;
      wr_line  = line;
      wr_off   = 11'(i);
      wr_tlast = with_last && (i == last);
      case (i)
        12:      wr_tdata = b12;
        13:      wr_tdata = b13;
        14:      wr_tdata = b14;
        15:      wr_tdata = b15;
        default: wr_tdata = 8'(i * 7 + 1);
      endcase
      rd_release = rel && (i == last);
      @(posedge clk);
      #1;
    end
    wr_we      = 1'b0;
    wr_tlast   = 1'b0;
    rd_release = 1'b0;
  endtask

  task automatic release_slot(input logic [1:0] line);
    rd_line    = line;
    rd_release = 1'b1;
    @(posedge clk);
    #1;
    rd_release = 1'b0;
  endtask

  task automatic check_slot(input string name, input logic [1:0] line,
                            input logic [15:0] len, input logic [11:0] vlan,
                            input logic tag, input logic valid);
    rd_line = line;
    rd_off  = 9'd31;
    #1;
    check({name, ".len"},   32'(body_length), 32'(len));
    check({name, ".vlan"},  32'(vlan_id),     32'(vlan));
    check({name, ".tag"},   32'(vlan_tagged), 32'(tag));
    check({name, ".valid"}, 32'(slot_valid),  32'(valid));
  endtask

  task automatic check_all_zero(input string name);
    rd_line = 2'd0;
    rd_off  = 9'd31;
    #1;
    check({name, ".tlast"}, 32'(tlast_flag),    32'd0);
    check({name, ".len"},   32'(body_length),   32'd0);
    check({name, ".vlan"},  32'(vlan_id),       32'd0);
    check({name, ".tag"},   32'(vlan_tagged),   32'd0);
    check({name, ".valid"}, 32'(slot_valid),    32'd0);
    check({name, ".occ"},   32'(occupancy),     32'd0);
    check({name, ".empty"}, 32'(empty),         32'd1);
    check({name, ".full"},  32'(full),          32'd0);
    check({name, ".err"},   32'(err_overwrite), 32'd0);
  endtask

  initial begin
    int highs;

    //              line  off    tl    len     vlan     tag   valid
    vecs[0] = '{2'd1, 9'd31, 1'b1, 16'd63, 12'hABC, 1'b1, 1'b1};
    vecs[1] = '{2'd1, 9'd30, 1'b0, 16'd63, 12'hABC, 1'b1, 1'b1};
    vecs[2] = '{2'd1, 9'd0,  1'b0, 16'd63, 12'hABC, 1'b1, 1'b1};
    vecs[3] = '{2'd0, 9'd31, 1'b1, 16'd59, 12'h000, 1'b0, 1'b1};
    vecs[4] = '{2'd2, 9'd31, 1'b1, 16'd14, 12'h000, 1'b0, 1'b1};
    vecs[5] = '{2'd2, 9'd32, 1'b0, 16'd14, 12'h000, 1'b0, 1'b1};
    vecs[6] = '{2'd3, 9'd31, 1'b0, 16'd0,  12'h000, 1'b0, 1'b0};

    rst_n = 1'b0; wr_we = 1'b0; wr_line = '0; wr_off = '0; wr_tdata = '0;
    wr_tlast = 1'b0; rd_line = '0; rd_off = '0; rd_release = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all_zero("reset");

    // Tagged (slot 1), untagged (slot 0), runt with TPID 0x8100 (slot 2).
    write_frame(2'd1, 63, 8'h81, 8'h00, 8'h0A, 8'hBC, 1'b1, 1'b0);
    check("tagged.occ", 32'(occupancy), 32'd1);
    write_frame(2'd0, 59, 8'h08, 8'h00, 8'h45, 8'h00, 1'b1, 1'b0);
    write_frame(2'd2, 14, 8'h81, 8'h00, 8'h0A, 8'hBC, 1'b1, 1'b0);
    check("three.occ",   32'(occupancy), 32'd3);
    check("three.empty", 32'(empty),     32'd0);

    foreach (vecs[k]) begin
      rd_line = vecs[k].line;
      rd_off  = vecs[k].off;
      #1;
      check($sformatf("vec%0d.tlast", k), 32'(tlast_flag),  32'(vecs[k].tl));
      check($sformatf("vec%0d.len", k),   32'(body_length), 32'(vecs[k].len));
      check($sformatf("vec%0d.vlan", k),  32'(vlan_id),     32'(vecs[k].vlan));
      check($sformatf("vec%0d.tag", k),   32'(vlan_tagged), 32'(vecs[k].tag));
      check($sformatf("vec%0d.valid", k), 32'(slot_valid),  32'(vecs[k].valid));
    end

    // Header-end flag is high for exactly one rd_off value.
    rd_line = 2'd1;
    highs = 0;
    for (int o = 0; o < 512; o++) begin
      rd_off = 9'(o);
      #1;
      if (tlast_flag) highs++;
    end
    check("tlast.count", 32'(highs), 32'd1);

    // Fill slot 3, then overwrite slot 2.
    write_frame(2'd3, 19, 8'h08, 8'h06, 8'h00, 8'h01, 1'b1, 1'b0);
    check("fill.occ",  32'(occupancy),     32'd4);
    check("fill.full", 32'(full),          32'd1);
    check("fill.err",  32'(err_overwrite), 32'd0);
    write_frame(2'd2, 9, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    check("ovw.err",  32'(err_overwrite), 32'd1);
    check("ovw.occ",  32'(occupancy),     32'd4);
    @(posedge clk); #1;
    check("ovw.err_drop", 32'(err_overwrite), 32'd0);
    check_slot("ovw.slot2", 2'd2, 16'd9, 12'h000, 1'b0, 1'b1);

    // Commit and release of slot 3 in the same cycle: commit wins.
    rd_line = 2'd3;
    write_frame(2'd3, 25, 8'h81, 8'h00, 8'h01, 8'h23, 1'b1, 1'b1);
    check("same.occ", 32'(occupancy), 32'd4);
    check_slot("same.slot3", 2'd3, 16'd25, 12'h123, 1'b1, 1'b1);

    // Valid release, then release of the now-invalid slot 1.
    release_slot(2'd1);
    check("rel.occ", 32'(occupancy), 32'd3);
    release_slot(2'd1);
    check("rel_inv.occ",   32'(occupancy),  32'd3);
    check("rel_inv.valid", 32'(slot_valid), 32'd0);
    check_slot("rel_inv.slot3", 2'd3, 16'd25, 12'h123, 1'b1, 1'b1);

    // Commit slot 1 while releasing slot 0.
    rd_line = 2'd0;
    write_frame(2'd1, 20, 8'h81, 8'h00, 8'h07, 8'h77, 1'b1, 1'b1);
    check("diff.occ", 32'(occupancy), 32'd3);
    check_slot("diff.slot0", 2'd0, 16'd0,  12'h000, 1'b0, 1'b0);
    check_slot("diff.slot1", 2'd1, 16'd20, 12'h777, 1'b1, 1'b1);

    // Restart: a tagged header is abandoned at offset 15, the new frame
    // ends at 14 so its TCI low byte is never seen.
    write_frame(2'd0, 15, 8'h81, 8'h00, 8'h0F, 8'hFF, 1'b0, 1'b0);
    write_frame(2'd0, 14, 8'h81, 8'h00, 8'h0F, 8'hFF, 1'b1, 1'b0);
    check("restart.occ", 32'(occupancy), 32'd4);
    check_slot("restart.slot0", 2'd0, 16'd14, 12'h000, 1'b0, 1'b1);

    // Mid-header reset discards everything.
    write_frame(2'd1, 10, 8'h81, 8'h00, 8'h0F, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst.occ_after", 32'(occupancy), 32'd0);
    check_slot("midrst.slot1", 2'd1, 16'd0, 12'h000, 1'b0, 1'b0);

    // Fresh frame after reset; TCI low byte arrives with wr_tlast.
    write_frame(2'd0, 15, 8'h81, 8'h00, 8'hF5, 8'h67, 1'b1, 1'b0);
    check("post.occ", 32'(occupancy),     32'd1);
    check("post.err", 32'(err_overwrite), 32'd0);
    check_slot("post.slot0", 2'd0, 16'd15, 12'h567, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
